single_bit_sync_filter: RTL and testbench

- Fast-domain consumer placed directly after the two-flop single-bit slow-to-fast synchronizer.
- Takes the synchronized level and applies a stability filter: the input must hold for FILT_CYC consecutive clka cycles before it is accepted.
- Produces a clean level, one-cycle rise/fall pulses and an optional saturating rising-edge counter for downstream control logic.

---
 rtl/single_bit_sync_filter.sv | 162 ++++++++++++++++
 tb/tb_single_bit_sync_filter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/single_bit_sync_filter.sv
// Stability filter after a two-flop synchronizer: clean level, rise/fall pulses, saturating rise counter.
// Define SYNC_FILT_EDGE_CNT_EN to build the edge counter; otherwise edge_cnt and cnt_sat are tied to 0.
module single_bit_sync_filter #(
    parameter int unsigned FILT_CYC = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clka,
    input  logic             rst,
    input  logic             din_sync,
    input  logic             cnt_clr,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             cnt_sat
);

    localparam int unsigned    QW        = $clog2(FILT_CYC + 1);
    localparam logic [QW-1:0]  QUAL_LAST = QW'(FILT_CYC - 1);
    localparam logic [QW-1:0]  QUAL_ONE  = QW'(1);

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_QUAL_H = 2'd1,
        ST_HIGH   = 2'd2,
        ST_QUAL_L = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // The qualification counter holds the number of consecutive samples of the
    // new level seen so far; acceptance happens on the FILT_CYC-th sample.
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (din_sync) begin
                    if (FILT_CYC == 1) begin
                        state_d = ST_HIGH;
                        qcnt_d  = '0;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = ST_QUAL_H;
                        qcnt_d  = QUAL_ONE;
                    end
                end
            end
            ST_QUAL_H: begin
                if (!din_sync) begin
                    state_d = ST_LOW;
                    qcnt_d  = '0;
                end else if (qcnt_q == QUAL_LAST) begin
                    state_d = ST_HIGH;
                    qcnt_d  = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    qcnt_d = qcnt_q + 1'b1;
                end
            end
            ST_HIGH: begin
                if (!din_sync) begin
                    if (FILT_CYC == 1) begin
                        state_d = ST_LOW;
                        qcnt_d  = '0;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = ST_QUAL_L;
                        qcnt_d  = QUAL_ONE;
                    end
                end
            end
            ST_QUAL_L: begin
                if (din_sync) begin
                    state_d = ST_HIGH;
                    qcnt_d  = '0;
                end else if (qcnt_q == QUAL_LAST) begin
                    state_d = ST_LOW;
                    qcnt_d  = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    qcnt_d = qcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_LOW;
                qcnt_d  = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q <= ST_LOW;
            qcnt_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef SYNC_FILT_EDGE_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    // A clear coinciding with a pending increment leaves 1 so that edge is kept.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = rise_q ? CNT_ONE : '0;
        end else if (rise_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        sat_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign edge_cnt = cnt_q;
    assign cnt_sat  = sat_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign edge_cnt       = '0;
    assign cnt_sat        = 1'b0;
`endif

endmodule

// File: tb/tb_single_bit_sync_filter.sv
// Bench for single_bit_sync_filter: FILT_CYC=4/CNT_W=8 and FILT_CYC=1/CNT_W=2 instances share stimulus.
module tb_single_bit_sync_filter;

`ifdef SYNC_FILT_EDGE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clka = 1'b0;
    logic       rst = 1'b1;
    logic       din_sync = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       l0, r0, f0, s0;
    logic [7:0] c0;
    logic       l1, r1, f1, s1;
    logic [1:0] c1;

    int checks = 0;
    int errors = 0;

    // Reference model: run length of samples disagreeing with the accepted level.
    int m_f[2]   = '{4, 1};
    int m_max[2] = '{255, 3};
    int m_run[2];
    int m_lvl[2];
    int m_rise[2];
    int m_fall[2];
    int m_cnt[2];
    int m_sat[2];

    always #5 clka = ~clka;

    single_bit_sync_filter #(.FILT_CYC(4), .CNT_W(8)) u_dut_f4 (
        .clka(clka), .rst(rst), .din_sync(din_sync), .cnt_clr(cnt_clr),
        .level_out(l0), .rise_pulse(r0), .fall_pulse(f0), .edge_cnt(c0), .cnt_sat(s0)
    );

    single_bit_sync_filter #(.FILT_CYC(1), .CNT_W(2)) u_dut_f1 (
        .clka(clka), .rst(rst), .din_sync(din_sync), .cnt_clr(cnt_clr),
        .level_out(l1), .rise_pulse(r1), .fall_pulse(f1), .edge_cnt(c1), .cnt_sat(s1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int old_rise;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_run[i] = 0; m_lvl[i] = 0; m_rise[i] = 0;
                m_fall[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
            end else begin
                old_rise  = m_rise[i];
                m_rise[i] = 0;
                m_fall[i] = 0;
                if (int'(din_sync) != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= m_f[i]) begin
                        m_lvl[i]  = int'(din_sync);
                        m_run[i]  = 0;
                        m_rise[i] = m_lvl[i];
                        m_fall[i] = 1 - m_lvl[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (cnt_clr) m_cnt[i] = old_rise;
                else if (old_rise == 1 && m_cnt[i] < m_max[i]) m_cnt[i]++;
                m_sat[i] = (m_cnt[i] == m_max[i]) ? 1 : 0;
            end
        end
    endtask

    task automatic compare_all();
        check("f4_level", l0, m_lvl[0]);
        check("f4_rise", r0, m_rise[0]);
        check("f4_fall", f0, m_fall[0]);
        check("f4_edge_cnt", c0, CNT_EN ? m_cnt[0] : 0);
        check("f4_cnt_sat", s0, CNT_EN ? m_sat[0] : 0);
        check("f4_excl", r0 & f0, 0);
        check("f1_level", l1, m_lvl[1]);
        check("f1_rise", r1, m_rise[1]);
        check("f1_fall", f1, m_fall[1]);
        check("f1_edge_cnt", c1, CNT_EN ? m_cnt[1] : 0);
        check("f1_cnt_sat", s1, CNT_EN ? m_sat[1] : 0);
    endtask

    task automatic step();
        @(posedge clka);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int n_rise;
        int n_fall;
        int found;
        int run_left;

        // Reset state
        rst = 1'b1; din_sync = 1'b0; cnt_clr = 1'b0;
        steps(3);
        check("reset_level", l0, 0);
        check("reset_edge_cnt", c0, 0);

        // Reset exit with din_sync already high
        din_sync = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("exit_level_pre", l0, 0);
            check("exit_rise_pre", r0, 0);
        end
        step();
        check("exit_level_4th", l0, 1);
        check("exit_rise_4th", r0, 1);
        step();
        check("exit_cnt_after", c0, CNT_EN ? 1 : 0);
        check("exit_rise_one_wide", r0, 0);

        // Return low, then a 3-cycle glitch, then a qualifying 4-cycle high
        din_sync = 1'b0;
        steps(6);
        din_sync = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("glitch_level", l0, 0);
        end
        din_sync = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("glitch_no_rise", r0, 0);
            check("glitch_no_fall", f0, 0);
        end
        check("glitch_cnt", c0, CNT_EN ? 1 : 0);
        din_sync = 1'b1;
        n_rise = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            n_rise += int'(r0);
        end
        check("post_glitch_rises", n_rise, 1);

        // Toggle every 6 cycles for 10 periods after clearing the counter
        din_sync = 1'b0;
        steps(6);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n_rise = 0;
        n_fall = 0;
        for (int h = 0; h < 20; h++) begin
            din_sync = (h % 2 == 0) ? 1'b1 : 1'b0;
            for (int j = 0; j < 6; j++) begin
                step();
                check("tog_rise_lag", r0, (din_sync && j == 3) ? 1 : 0);
                check("tog_fall_lag", f0, (!din_sync && j == 3) ? 1 : 0);
                n_rise += int'(r0);
                n_fall += int'(f0);
            end
        end
        steps(2);
        check("tog_rise_count", n_rise, 10);
        check("tog_fall_count", n_fall, 10);
        check("tog_edge_cnt", c0, CNT_EN ? 10 : 0);

        // Saturation on the CNT_W=2 instance
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            din_sync = 1'b1;
            steps(2);
            check("sat_cnt_seq", c1, CNT_EN ? ((k + 1 > 3) ? 3 : k + 1) : 0);
            check("sat_flag_seq", s1, (CNT_EN && k >= 2) ? 1 : 0);
            din_sync = 1'b0;
            steps(2);
        end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("sat_clr_cnt", c1, 0);
        check("sat_clr_flag", s1, 0);

        // Clear coinciding with an increment, edge_cnt=5 beforehand
        for (int k = 0; k < 5; k++) begin
            din_sync = 1'b1;
            steps(5);
            din_sync = 1'b0;
            steps(5);
        end
        check("pre_clr_cnt5", c0, CNT_EN ? 5 : 0);
        din_sync = 1'b1;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            step();
            if (r0) found = 1;
        end
        check("clr_rise_seen", found, 1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_with_inc", c0, CNT_EN ? 1 : 0);

        // Reset two cycles into QUAL_L
        steps(3);
        din_sync = 1'b0;
        steps(2);
        check("qual_l_level_held", l0, 1);
        rst = 1'b1;
        step();
        check("rst_qual_l_level", l0, 0);
        check("rst_qual_l_fall", f0, 0);
        check("rst_qual_l_cnt", c0, 0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check("after_rst_no_fall", f0, 0);
        end

        // Randomized runs with occasional clear and reset
        run_left = 0;
        for (int k = 0; k < 500; k++) begin
            if (run_left == 0) begin
                din_sync = 1'($urandom_range(0, 1));
                run_left = $urandom_range(1, 7);
            end
            cnt_clr = ($urandom_range(0, 7) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            step();
            run_left--;
        end
        rst = 1'b0;
        cnt_clr = 1'b0;
        steps(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
